usb_rx_timer: RTL and testbench

Bit/byte timing generator for the USB 1.0 receive path; the counterpart of the transmit timer.
- Free-runs a per-bit phase counter at the oversampled clock rate.
- Re-aligns the counter on every line transition reported by the edge detector.
- Emits a mid-bit sample strobe, an end-of-bit pulse and a byte-complete pulse.
- Consumers: the NRZI decoder, the bit-unstuffer and the RX shift register.

---
 rtl/usb_rx_pkg.sv | 11 +
 rtl/usb_rx_timer_cnt.sv | 49 ++++
 rtl/usb_rx_timer.sv | 64 ++++++
 tb/tb_usb_rx_timer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared defaults and types for the USB 1.0 receive timer.
// Imported by the timer top and its bench.
package usb_rx_pkg;

  localparam int CLKS_PER_BIT_DEF  = 8;
  localparam int SAMPLE_PHASE_DEF  = 3;
  localparam int BITS_PER_BYTE_DEF = 8;

  typedef logic [$clog2(BITS_PER_BYTE_DEF):0] rx_bitcnt_t;

endpackage

// File: rtl/usb_rx_timer_cnt.sv
// Rollover counter: wraps to 0 after rollover_val counts and
// raises a one-cycle registered flag on the cycle after the wrap.
module usb_rx_timer_cnt #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    at_last;

  assign at_last = (count_q == (rollover_val - NUM_CNT_BITS'(1)));

  always_comb begin
    count_d = count_q;
    flag_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (at_last) begin
        count_d = '0;
        flag_d  = 1'b1;
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/usb_rx_timer.sv
// USB 1.0 RX bit/byte timer: phase counter resynced on line edges,
// mid-bit sample strobe, end-of-bit and byte-complete pulses.
module usb_rx_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
  parameter int SAMPLE_PHASE  = SAMPLE_PHASE_DEF,
  parameter int BITS_PER_BYTE = BITS_PER_BYTE_DEF,
  localparam int PW = $clog2(CLKS_PER_BIT),
  localparam int CW = $clog2(BITS_PER_BYTE) + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          timer_en,
  input  logic          timer_clr,
  input  logic          d_edge,
  input  logic          stuff_skip,
  output logic          shift_strobe,
  output logic          bit_done,
  output logic          byte_done,
  output logic [CW-1:0] bit_cnt
);

  localparam logic [PW-1:0] SAMP_PH = PW'(SAMPLE_PHASE);
  localparam logic [PW-1:0] LAST_PH = PW'(CLKS_PER_BIT - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          run;

  assign run = timer_en & ~timer_clr;

  always_comb begin
    phase_d = phase_q;
    unique case (1'b1)
      timer_clr:          phase_d = '0;
      !timer_en:          phase_d = phase_q;
      d_edge:             phase_d = PW'(1);
      phase_q == LAST_PH: phase_d = '0;
      default:            phase_d = phase_q + PW'(1);
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign shift_strobe = run & (phase_q == SAMP_PH);
  assign bit_done     = run & (phase_q == LAST_PH);

  // stuffed bits carry no data, so they never advance the byte
  usb_rx_timer_cnt #(
    .NUM_CNT_BITS (CW)
  ) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (timer_clr),
    .count_enable  (shift_strobe & ~stuff_skip),
    .rollover_val  (CW'(BITS_PER_BYTE)),
    .count_out     (bit_cnt),
    .rollover_flag (byte_done)
  );

endmodule

// File: tb/tb_usb_rx_timer.sv
// Directed bench for usb_rx_timer with default parameters.
// Inputs change 1 time unit after posedge; outputs checked 1 unit later.
module tb_usb_rx_timer;
  import usb_rx_pkg::*;

  logic       clk;
  logic       n_rst;
  logic       timer_en;
  logic       timer_clr;
  logic       d_edge;
  logic       stuff_skip;
  logic       shift_strobe;
  logic       bit_done;
  logic       byte_done;
  rx_bitcnt_t bit_cnt;

  int checks   = 0;
  int failures = 0;

  usb_rx_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .timer_en     (timer_en),
    .timer_clr    (timer_clr),
    .d_edge       (d_edge),
    .stuff_skip   (stuff_skip),
    .shift_strobe (shift_strobe),
    .bit_done     (bit_done),
    .byte_done    (byte_done),
    .bit_cnt      (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst      = 1'b0;
    timer_en   = 1'b0;
    timer_clr  = 1'b0;
    d_edge     = 1'b0;
    stuff_skip = 1'b0;
    cyc();
    cyc();
    #1;
    chk("rst_strobe", 32'(shift_strobe), 0);
    chk("rst_bitdone", 32'(bit_done), 0);
    chk("rst_bytedone", 32'(byte_done), 0);
    chk("rst_bitcnt", 32'(bit_cnt), 0);
    n_rst = 1'b1;
    cyc();

    // free run from phase 0
    timer_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      #1;
      chk("t1_strobe", 32'(shift_strobe), 32'(k % 8 == 3));
      chk("t1_bitdone", 32'(bit_done), 32'(k % 8 == 7));
      cyc();
    end
    #1;
    chk("t1_bitcnt", 32'(bit_cnt), 3);

    // resync on an edge at phase 5
    timer_clr = 1'b1;
    #1;
    chk("t2_clr_strobe", 32'(shift_strobe), 0);
    cyc();
    timer_clr = 1'b0;
    repeat (5) cyc();
    d_edge = 1'b1;
    #1;
    chk("t2_edge_strobe", 32'(shift_strobe), 0);
    cyc();
    d_edge = 1'b0;
    for (int m = 1; m < 20; m++) begin
      #1;
      chk("t2_strobe", 32'(shift_strobe), 32'(m % 8 == 3));
      chk("t2_bitdone", 32'(bit_done), 32'(m % 8 == 7));
      cyc();
    end
    #1;
    chk("t2_bitcnt", 32'(bit_cnt), 4);

    // full byte of counted bits
    timer_clr = 1'b1;
    cyc();
    timer_clr = 1'b0;
    for (int n = 0; n < 64; n++) begin
      #1;
      chk("t3_strobe", 32'(shift_strobe), 32'(n % 8 == 3));
      chk("t3_bytedone", 32'(byte_done), 32'(n == 60));
      if (n % 8 == 4)
        chk("t3_bitcnt", 32'(bit_cnt), 32'((n / 8 + 1) % 8));
      cyc();
    end

    // 4th strobe stuffed; stray stuff_skip off-strobe ignored
    for (int p = 0; p < 72; p++) begin
      stuff_skip = (p == 27) || (p == 30);
      #1;
      chk("t4_bytedone", 32'(byte_done), 32'(p == 68));
      if (p % 8 == 4)
        chk("t4_bitcnt", 32'(bit_cnt),
            32'((p / 8 < 3) ? (p / 8 + 1) : ((p / 8) % 8)));
      cyc();
    end
    stuff_skip = 1'b0;

    // edge exactly on the sample phase
    repeat (3) cyc();
    d_edge = 1'b1;
    #1;
    chk("t5_edge_strobe", 32'(shift_strobe), 1);
    cyc();
    d_edge = 1'b0;
    #1;
    chk("t5_ph1", 32'(shift_strobe), 0);
    cyc();
    #1;
    chk("t5_ph2", 32'(shift_strobe), 0);
    cyc();
    #1;
    chk("t5_ph3", 32'(shift_strobe), 1);
    cyc();
    #1;
    chk("t5_bitcnt", 32'(bit_cnt), 2);
    d_edge = 1'b1;
    for (int e = 0; e < 10; e++) begin
      #1;
      chk("t5_every_edge", 32'(shift_strobe), 0);
      cyc();
    end
    d_edge = 1'b0;

    // clear on the final counted strobe
    timer_clr = 1'b1;
    cyc();
    timer_clr = 1'b0;
    repeat (59) cyc();
    timer_clr = 1'b1;
    #1;
    chk("t6_clr_strobe", 32'(shift_strobe), 0);
    chk("t6_pre_bitcnt", 32'(bit_cnt), 7);
    cyc();
    timer_clr = 1'b0;
    #1;
    chk("t6_clr_bytedone", 32'(byte_done), 0);
    chk("t6_clr_bitcnt", 32'(bit_cnt), 0);

    // freeze mid-bit at phase 2
    cyc();
    cyc();
    timer_en = 1'b0;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk("t6_hold_strobe", 32'(shift_strobe), 0);
      cyc();
    end
    timer_en = 1'b1;
    #1;
    chk("t6_resume_ph2", 32'(shift_strobe), 0);
    cyc();
    #1;
    chk("t6_resume_ph3", 32'(shift_strobe), 1);
    cyc();
    #1;
    chk("t6_resume_bitcnt", 32'(bit_cnt), 1);

    // async reset between edges
    n_rst = 1'b0;
    #1;
    chk("t6_async_bitcnt", 32'(bit_cnt), 0);
    chk("t6_async_strobe", 32'(shift_strobe), 0);
    n_rst = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
